// File: rtl/msr_seq_shifter.sv
// msr_seq_shifter: WIDTH-bit shift/rotate register that executes multi-step
// commands (one step per clock) with a start/busy/done handshake, plus
// parallel load and serial in/out.
// Optional build macro MSR_DOUBLE_STEP_EN: two steps per RUN cycle, with the
// final odd step done singly. Final PO is the same as in the default build.
module msr_seq_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] PO,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] M_ROR = 3'b001;
  localparam logic [2:0] M_ROL = 3'b010;
  localparam logic [2:0] M_SHR = 3'b011;
  localparam logic [2:0] M_SHL = 3'b100;
  localparam logic [2:0] M_SRA = 3'b101;

  state_t           state, state_nxt;
  logic [2:0]       mode_q, mode_nxt;
  logic [AMT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] po_nxt;
  logic             sout_nxt, busy_nxt, done_nxt;
  logic [WIDTH:0]   r1;
`ifdef MSR_DOUBLE_STEP_EN
  logic [WIDTH:0]   r2;
`endif

  // One step of the selected operation; result is {new sout, new PO}.
  // HOLD and the unused codes keep both PO and sout.
  function automatic logic [WIDTH:0] step_fn(input logic [2:0] m,
                                             input logic [WIDTH-1:0] v,
                                             input logic s_in,
                                             input logic s_out);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v) >>> 1;
    case (m)
      M_ROR:   return {v[0], v[0], v[WIDTH-1:1]};
      M_ROL:   return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      M_SHR:   return {v[0], s_in, v[WIDTH-1:1]};
      M_SHL:   return {v[WIDTH-1], v[WIDTH-2:0], s_in};
      M_SRA:   return {v[0], sv};
      default: return {s_out, v};
    endcase
  endfunction

  // Next-state and datapath: IDLE accepts load/start, RUN steps and counts down.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    cnt_nxt   = cnt;
    po_nxt    = PO;
    sout_nxt  = sout;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    r1        = step_fn(mode_q, PO, sin, sout);
`ifdef MSR_DOUBLE_STEP_EN
    r2        = step_fn(mode_q, r1[WIDTH-1:0], sin, r1[WIDTH]);
`endif
    case (state)
      IDLE: begin
        if (load) begin
          // load wins over a simultaneous start; that start is dropped
          po_nxt = load_val;
        end else if (start) begin
          if (amt == '0) begin
            done_nxt = 1'b1;
          end else begin
            mode_nxt  = mode;
            cnt_nxt   = amt;
            busy_nxt  = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
`ifdef MSR_DOUBLE_STEP_EN
        if (cnt > AMT_W'(1)) begin
          {sout_nxt, po_nxt} = r2;
          cnt_nxt = cnt - AMT_W'(2);
        end else begin
          {sout_nxt, po_nxt} = r1;
          cnt_nxt = cnt - AMT_W'(1);
        end
        if (cnt <= AMT_W'(2)) begin
`else
        {sout_nxt, po_nxt} = r1;
        cnt_nxt = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
`endif
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and register update; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= '0;
      cnt    <= '0;
      PO     <= '0;
      sout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
      cnt    <= cnt_nxt;
      PO     <= po_nxt;
      sout   <= sout_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_msr_seq_shifter.sv
// Testbench for msr_seq_shifter (WIDTH=8, AMT_W=3): command vector table with
// a scoreboard queue, plus hand-written handshake and reset sequences.
module tb_msr_seq_shifter;

  logic       clk = 1'b0;
  logic       rst, load, start, sin;
  logic [7:0] load_val;
  logic [2:0] mode, amt;
  logic [7:0] PO;
  logic       sout, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] lv;
    logic [2:0] md;
    logic [2:0] am;
    logic       si;
    logic [7:0] po;
    logic       so;
  } vec_t;

  typedef struct {
    logic [7:0] po;
    logic       so;
    int         nb;
  } exp_t;

  vec_t vt[13];
  exp_t sb[$];

  msr_seq_shifter #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .mode(mode), .amt(amt), .sin(sin), .PO(PO), .sout(sout), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic int exp_busy(input int a);
`ifdef MSR_DOUBLE_STEP_EN
    return (a + 1) / 2;
`else
    return a;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Load a word, start a command, then watch busy/done and score the result.
  task automatic run_cmd(input vec_t v, input int idx);
    exp_t e, got;
    int   nb;
    bit   seen;
    @(negedge clk);
    load = 1'b1; load_val = v.lv; start = 1'b0;
    @(negedge clk);
    load = 1'b0; start = 1'b1; mode = v.md; amt = v.am; sin = v.si;
    e.po = v.po; e.so = v.so; e.nb = exp_busy(int'(v.am));
    sb.push_back(e);
    nb = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin seen = 1'b1; break; end
      if (busy) nb++;
    end
    if (!seen) begin
      chk($sformatf("v%0d_done_timeout", idx), 0, 1);
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      chk($sformatf("v%0d_po", idx), PO, got.po);
      chk($sformatf("v%0d_sout", idx), sout, got.so);
      chk($sformatf("v%0d_busy_cycles", idx), nb, got.nb);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", idx), done, 0);
    end
  endtask

  initial begin
    int cnt_b, cnt_d;
    vt[0]  = '{8'hA5, 3'b001, 3'd3, 1'b0, 8'hB4, 1'b1};
    vt[1]  = '{8'h81, 3'b010, 3'd1, 1'b0, 8'h03, 1'b1};
    vt[2]  = '{8'h90, 3'b101, 3'd2, 1'b0, 8'hE4, 1'b0};
    vt[3]  = '{8'h00, 3'b011, 3'd4, 1'b1, 8'hF0, 1'b0};
    vt[4]  = '{8'hC3, 3'b100, 3'd2, 1'b1, 8'h0F, 1'b1};
    vt[5]  = '{8'h3C, 3'b000, 3'd5, 1'b0, 8'h3C, 1'b1};
    vt[6]  = '{8'h5A, 3'b111, 3'd2, 1'b0, 8'h5A, 1'b1};
    vt[7]  = '{8'h96, 3'b101, 3'd7, 1'b0, 8'hFF, 1'b0};
    vt[8]  = '{8'h6B, 3'b010, 3'd7, 1'b0, 8'hB5, 1'b1};
    vt[9]  = '{8'hFF, 3'b011, 3'd7, 1'b0, 8'h01, 1'b1};
    vt[10] = '{8'h77, 3'b001, 3'd0, 1'b0, 8'h77, 1'b1};
    vt[11] = '{8'hA5, 3'b001, 3'd5, 1'b0, 8'h2D, 1'b0};
    vt[12] = '{8'h81, 3'b110, 3'd3, 1'b0, 8'h81, 1'b0};

    rst = 1'b1; load = 1'b0; start = 1'b0; sin = 1'b0;
    load_val = 8'h00; mode = 3'b000; amt = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset_po", PO, 8'h00);
    chk("reset_busy", busy, 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_cmd(vt[i], i);

    // Asynchronous reset mid-cycle, checked before any clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_po", PO, 8'h00);
    chk("async_rst_sout", sout, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // start and load together in IDLE: load wins, no command.
    @(negedge clk);
    load = 1'b1; load_val = 8'h3C; start = 1'b1; mode = 3'b001; amt = 3'd3;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    chk("ld_st_po", PO, 8'h3C);
    cnt_b = 0; cnt_d = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) cnt_b++;
      if (done) cnt_d++;
    end
    chk("ld_st_busy", cnt_b, 0);
    chk("ld_st_done", cnt_d, 0);

    // load and start during RUN are ignored.
    @(negedge clk);
    load = 1'b1; load_val = 8'hA5;
    @(negedge clk);
    load = 1'b0; start = 1'b1; mode = 3'b001; amt = 3'd3; sin = 1'b0;
    @(negedge clk);
    load = 1'b1; load_val = 8'hFF; start = 1'b1; mode = 3'b100; amt = 3'd7;
    cnt_d = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin cnt_d = 1; break; end
      @(negedge clk);
    end
    load = 1'b0; start = 1'b0;
    chk("run_load_done_seen", cnt_d, 1);
    chk("run_load_po", PO, 8'hB4);
    @(negedge clk);
    chk("run_start_ignored", busy, 0);

    // Reset during step 2 of ROR amt=7: clears state, no done pulse.
    @(negedge clk);
    load = 1'b1; load_val = 8'hA5;
    @(negedge clk);
    load = 1'b0; start = 1'b1; mode = 3'b001; amt = 3'd7;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_po", PO, 8'h00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sout", sout, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt_b = 0; cnt_d = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy) cnt_b++;
      if (done) cnt_d++;
    end
    chk("mid_rst_no_busy", cnt_b, 0);
    chk("mid_rst_no_done", cnt_d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
